// File: rtl/decompressor_controller_pkg.sv
// Shared definitions for the compressor/decompressor controller pair.
//   BURST_WIDTH_DEF : default data-beat width
//   HDR_BEATS_DEF   : default number of header beats at the head of a packet
//   ctrl_state_t    : FSM state codes exposed on the 'state' status port
//   sat_inc16       : saturating 16-bit increment used by beat counters
package decompressor_controller_pkg;

  localparam int BURST_WIDTH_DEF = 256;
  localparam int HDR_BEATS_DEF   = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_DATA = 3'd2,
    ST_DROP = 3'd3
  } ctrl_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/decompressor_controller_if.sv
// AXI-stream bundle between the decompressor controller and its consumer.
//   m_tdata  : beat data          (master -> slave)
//   m_tvalid : beat valid         (master -> slave)
//   m_tlast  : last beat of packet(master -> slave)
//   m_tready : consumer ready     (slave -> master)
interface decompressor_controller_if
  import decompressor_controller_pkg::*;
#(
  parameter int BURST_WIDTH = BURST_WIDTH_DEF
);

  logic [BURST_WIDTH-1:0] m_tdata;
  logic                   m_tvalid;
  logic                   m_tlast;
  logic                   m_tready;

  modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
  modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);

endinterface

// File: rtl/decompressor_controller_axis_out_reg.sv
// Single-entry AXI-stream output register.
//   clk, reset_n : clock, asynchronous active-low reset
//   load         : capture din/lin this cycle (caller only asserts it when can_load=1)
//   din, lin     : data and last flag of the entry being captured
//   can_load     : register is empty or is being drained this cycle
//   axis         : AXI-stream master side; m_tvalid is the occupancy bit
module axis_out_reg
  import decompressor_controller_pkg::*;
#(
  parameter int BURST_WIDTH = BURST_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load,
  input  logic [BURST_WIDTH-1:0] din,
  input  logic                   lin,
  output logic                   can_load,
  decompressor_controller_if.master axis
);

  // Accepting while the current beat is handed off gives back-to-back beats.
  assign can_load = !axis.m_tvalid || axis.m_tready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      axis.m_tdata  <= '0;
      axis.m_tlast  <= 1'b0;
      axis.m_tvalid <= 1'b0;
    end else if (load) begin
      axis.m_tdata  <= din;
      axis.m_tlast  <= lin;
      axis.m_tvalid <= 1'b1;
    end else if (axis.m_tready) begin
      axis.m_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/decompressor_controller.sv
// Packet controller draining a first-word-fall-through FIFO into AXI-stream.
// Packets must start with a header beat; packets that do not are popped and
// discarded (DROP). Headers shorter than HDR_BEATS are forwarded but flagged.
//   clk, reset_n          : clock, asynchronous active-low reset
//   fifo_dout/last/hdr    : FIFO head entry and its flags
//   empty_outfifo         : FIFO empty
//   pop_outfifo           : consume FIFO head this cycle
//   m_axis                : AXI-stream master (m_tdata/m_tvalid/m_tlast/m_tready)
//   state                 : current FSM state code
//   beat_cnt              : beats accepted for the current packet (saturating)
//   pkt_cnt               : packets fully transmitted (wrapping)
//   err_hdr               : sticky header-protocol error
module decompressor_controller
  import decompressor_controller_pkg::*;
#(
  parameter int BURST_WIDTH = BURST_WIDTH_DEF,
  parameter int HDR_BEATS   = HDR_BEATS_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [BURST_WIDTH-1:0] fifo_dout,
  input  logic                   fifo_last,
  input  logic                   fifo_hdr,
  input  logic                   empty_outfifo,
  output logic                   pop_outfifo,
  decompressor_controller_if.master m_axis,
  output logic [2:0]             state,
  output logic [15:0]            beat_cnt,
  output logic [31:0]            pkt_cnt,
  output logic                   err_hdr
);

  ctrl_state_t state_reg, state_next;
  logic [15:0] beat_cnt_reg, beat_cnt_next;
  logic [31:0] pkt_cnt_reg;
  logic        err_reg, err_next;
  logic        load, pop_c, can_load, hdr_done;

  // In HDR every accepted beat so far is a header beat, so beat_cnt doubles
  // as the header count; true when the beat being loaded completes the header.
  assign hdr_done = ({1'b0, beat_cnt_reg} + 17'd1) >= 17'(HDR_BEATS);

  always_comb begin
    state_next    = state_reg;
    beat_cnt_next = beat_cnt_reg;
    err_next      = err_reg;
    load          = 1'b0;
    pop_c         = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!empty_outfifo) begin
          if (fifo_hdr) begin
            if (can_load) begin
              load          = 1'b1;
              pop_c         = 1'b1;
              beat_cnt_next = 16'd1;
              if (!fifo_last) state_next = (HDR_BEATS > 1) ? ST_HDR : ST_DATA;
            end
          end else begin
            // Leave the bad entry in the FIFO; DROP pops it with the rest.
            err_next   = 1'b1;
            state_next = ST_DROP;
          end
        end
      end
      ST_HDR: begin
        if (!empty_outfifo && can_load) begin
          load          = 1'b1;
          pop_c         = 1'b1;
          beat_cnt_next = sat_inc16(beat_cnt_reg);
          if (!fifo_hdr) err_next = 1'b1;
          if (fifo_last)                 state_next = ST_IDLE;
          else if (!fifo_hdr || hdr_done) state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (!empty_outfifo && can_load) begin
          load          = 1'b1;
          pop_c         = 1'b1;
          beat_cnt_next = sat_inc16(beat_cnt_reg);
          if (fifo_last) state_next = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (!empty_outfifo) begin
          pop_c = 1'b1;
          if (fifo_last) state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Gate with reset so no pop is issued while the block is held in reset.
  assign pop_outfifo = pop_c & reset_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      beat_cnt_reg <= '0;
      err_reg      <= 1'b0;
      pkt_cnt_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      beat_cnt_reg <= beat_cnt_next;
      err_reg      <= err_next;
      if (m_axis.m_tvalid && m_axis.m_tready && m_axis.m_tlast)
        pkt_cnt_reg <= pkt_cnt_reg + 32'd1;
    end
  end

  axis_out_reg #(.BURST_WIDTH(BURST_WIDTH)) u_out_reg (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .din      (fifo_dout),
    .lin      (fifo_last),
    .can_load (can_load),
    .axis     (m_axis)
  );

  assign state    = state_reg;
  assign beat_cnt = beat_cnt_reg;
  assign pkt_cnt  = pkt_cnt_reg;
  assign err_hdr  = err_reg;

endmodule

// File: tb/tb_decompressor_controller.sv
// Self-checking bench: packet-level reference model (which beats survive,
// expected counters and error flag) plus a FIFO model driving the DUT.
module tb_decompressor_controller;
  import decompressor_controller_pkg::*;

  localparam int BW = 256;
  localparam int HB = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [BW-1:0] fifo_dout;
  logic          fifo_last, fifo_hdr, empty_outfifo, pop_outfifo;
  logic [2:0]    state;
  logic [15:0]   beat_cnt;
  logic [31:0]   pkt_cnt;
  logic          err_hdr;

  decompressor_controller_if #(.BURST_WIDTH(BW)) axis ();

  decompressor_controller #(.BURST_WIDTH(BW), .HDR_BEATS(HB)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .fifo_dout     (fifo_dout),
    .fifo_last     (fifo_last),
    .fifo_hdr      (fifo_hdr),
    .empty_outfifo (empty_outfifo),
    .pop_outfifo   (pop_outfifo),
    .m_axis        (axis),
    .state         (state),
    .beat_cnt      (beat_cnt),
    .pkt_cnt       (pkt_cnt),
    .err_hdr       (err_hdr)
  );

  typedef struct {logic [BW-1:0] data; logic last; logic hdr; logic keep;} ent_t;
  typedef struct {logic [BW-1:0] data; logic last;} beat_t;

  ent_t  fq[$];   // FIFO contents
  beat_t xq[$];   // beats expected on the stream, in order

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_pkt = '0;
  logic [15:0] m_beat = '0;
  logic        m_err = 1'b0;

  int cyc = 0, mode = 0, pops = 0, xfers = 0, pkt_no = 0;
  int xfer_cyc[$];
  bit saw_data = 0;
  bit prev_stall = 0;
  logic [BW-1:0] prev_data;
  logic prev_last;
  bit lat_pend = 0;
  logic [BW-1:0] lat_data;

  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] rand_word();
    logic [BW-1:0] w;
    for (int i = 0; i < BW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // kind 0: HB header beats + na data beats; 1: na header beats (<HB) + nb data
  // beats; 2: single header beat that is also last; 3: na beats, no header.
  task automatic add_packet(input int kind, input int na, input int nb);
    int len;
    bit keep;
    ent_t e;
    len  = (kind == 0) ? HB + na : (kind == 1) ? na + nb : (kind == 2) ? 1 : na;
    keep = (kind != 3);
    for (int i = 0; i < len; i++) begin
      e.data = rand_word();
      e.last = (i == len - 1);
      e.keep = keep;
      case (kind)
        0:       e.hdr = (i < HB);
        1:       e.hdr = (i < na) ? 1'b1 : (i == na) ? 1'b0 : 1'($urandom_range(0, 1));
        2:       e.hdr = 1'b1;
        default: e.hdr = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      endcase
      fq.push_back(e);
      if (keep) xq.push_back('{data: e.data, last: e.last});
    end
    if (keep) begin
      m_pkt  = m_pkt + 32'd1;
      m_beat = 16'(len);
    end
    if (kind == 1 || kind == 3) m_err = 1'b1;
    $display("pkt %0d kind=%0d len=%0d forwarded=%0d", pkt_no, kind, len, keep);
    pkt_no++;
  endtask

  task automatic step(input bit rst_in_data, output bit did_rst);
    beat_t b;
    ent_t  e;
    did_rst = 0;
    @(negedge clk);
    if (fq.size() > 0 && !(mode == 2 && $urandom_range(0, 3) == 0)) begin
      fifo_dout = fq[0].data; fifo_last = fq[0].last; fifo_hdr = fq[0].hdr;
      empty_outfifo = 1'b0;
    end else begin
      fifo_dout = '0; fifo_last = 1'b0; fifo_hdr = 1'b0; empty_outfifo = 1'b1;
    end
    axis.m_tready = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
    #1;
    if (rst_in_data && state == 3'd2 && axis.m_tvalid) begin
      reset_n = 1'b0;
      did_rst = 1;
      return;
    end
    chk("state_code_legal", {255'd0, state > 3'd3}, '0);
    if (lat_pend) begin
      chk("latency_valid", axis.m_tvalid, 1);
      chk("latency_data", axis.m_tdata, lat_data);
      lat_pend = 0;
    end
    if (prev_stall) begin
      chk("hold_valid", axis.m_tvalid, 1);
      chk("hold_data", axis.m_tdata, prev_data);
      chk("hold_last", axis.m_tlast, prev_last);
    end
    if (state == 3'd2) saw_data = 1;
    if (axis.m_tvalid && axis.m_tready) begin
      if (xq.size() == 0) chk("unexpected_beat", 1, 0);
      else begin
        b = xq.pop_front();
        chk("beat_data", axis.m_tdata, b.data);
        chk("beat_last", axis.m_tlast, b.last);
      end
      xfers++;
      xfer_cyc.push_back(cyc);
    end
    if (pop_outfifo) begin
      if (empty_outfifo) chk("pop_while_empty", 1, 0);
      else begin
        e = fq.pop_front();
        pops++;
        if (e.keep) begin lat_pend = 1; lat_data = e.data; end
      end
    end
    prev_stall = axis.m_tvalid && !axis.m_tready;
    prev_data  = axis.m_tdata;
    prev_last  = axis.m_tlast;
    cyc++;
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    bit d;
    while (fq.size() > 0 || xq.size() > 0 || axis.m_tvalid) begin
      step(0, d);
      n++;
      if (n > max_cyc) begin chk("drain_timeout", n, max_cyc); break; end
    end
    step(0, d);  // let the final edge settle the FSM
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_pkt_cnt"}, pkt_cnt, m_pkt);
    chk({tag, "_beat_cnt"}, beat_cnt, m_beat);
    chk({tag, "_err_hdr"}, err_hdr, m_err);
    chk({tag, "_state"}, state, 0);
  endtask

  initial begin
    int x0, p0, n;
    bit d;
    // Reset state, with a header entry waiting so a pop would be visible.
    fifo_dout = rand_word(); fifo_last = 1'b0; fifo_hdr = 1'b1; empty_outfifo = 1'b0;
    axis.m_tready = 1'b1;
    #2;
    chk("rst_state", state, 0);
    chk("rst_tvalid", axis.m_tvalid, 0);
    chk("rst_tlast", axis.m_tlast, 0);
    chk("rst_tdata", axis.m_tdata, 0);
    chk("rst_pop", pop_outfifo, 0);
    chk("rst_beat_cnt", beat_cnt, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_err_hdr", err_hdr, 0);
    empty_outfifo = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Full-throughput packet: 4 header + 3 data beats.
    mode = 0; x0 = xfers; xfer_cyc.delete();
    add_packet(0, 3, 0);
    drain(100);
    chk("tput_beats", xfers - x0, 7);
    if (xfer_cyc.size() == 7) chk("tput_consecutive", xfer_cyc[6] - xfer_cyc[0], 6);
    else chk("tput_beat_list", xfer_cyc.size(), 7);
    chk_status("tput");

    // Same packet under toggling ready.
    mode = 1;
    add_packet(0, 3, 0);
    drain(100);
    chk_status("toggle");

    // Packet without a header: dropped entirely, then a good one.
    mode = 0; x0 = xfers; p0 = pops;
    add_packet(3, 5, 0);
    drain(100);
    chk("drop_no_beats", xfers - x0, 0);
    chk("drop_pops", pops - p0, 5);
    chk_status("drop");
    add_packet(0, 2, 0);
    drain(100);
    chk_status("after_drop");

    // Short header of 2 beats followed by 3 data beats.
    saw_data = 0;
    add_packet(1, 2, 3);
    drain(100);
    chk("short_hdr_saw_data", saw_data, 1);
    chk_status("short_hdr");

    // Randomised traffic with random ready and FIFO bubbles.
    mode = 2;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: add_packet(0, $urandom_range(0, 4), 0);
        1: add_packet(1, $urandom_range(1, HB - 1), $urandom_range(1, 3));
        2: add_packet(2, 0, 0);
        default: add_packet(3, $urandom_range(1, 5), 0);
      endcase
    end
    drain(5000);
    chk_status("random");

    // Packet counter wrap.
    mode = 0;
    @(negedge clk);
    force dut.pkt_cnt_reg = 32'hFFFF_FFFF;
    #1 release dut.pkt_cnt_reg;
    m_pkt = 32'hFFFF_FFFF;
    chk("wrap_preset", pkt_cnt, 32'hFFFF_FFFF);
    add_packet(0, 1, 0);
    drain(100);
    chk("wrap_pkt_cnt", pkt_cnt, 0);

    // Asynchronous reset while a beat is held in DATA.
    add_packet(0, 3, 0);
    d = 0; n = 0;
    while (!d && n < 100) begin step(1, d); n++; end
    if (!d) chk("areset_reached_data", 0, 1);
    #1;
    chk("areset_tvalid", axis.m_tvalid, 0);
    chk("areset_state", state, 0);
    chk("areset_tdata", axis.m_tdata, 0);
    chk("areset_pop", pop_outfifo, 0);
    chk("areset_pkt_cnt", pkt_cnt, 0);
    chk("areset_beat_cnt", beat_cnt, 0);
    chk("areset_err_hdr", err_hdr, 0);
    xq.delete();
    foreach (fq[i]) fq[i].keep = 1'b0;
    lat_pend = 0; prev_stall = 0;
    m_pkt = '0; m_beat = '0;
    m_err = (fq.size() > 0);  // leftover data beats lack a header
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    p0 = pops; x0 = xfers;
    n = fq.size();
    drain(100);
    chk("areset_leftover_popped", pops - p0, n);
    chk("areset_leftover_no_beats", xfers - x0, 0);
    chk_status("areset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decompressor_controller.md
DECOMPRESSOR_CONTROLLER -- requirements
Module: decompressor_controller

Interface
REQ-001 Parameter: BURST_WIDTH, default 256, width of data beats.
REQ-002 Parameter: HDR_BEATS, default 4, number of header beats expected at the head of each packet.
REQ-003 clk  input  1  the block's single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert and active-low.
REQ-005 fifo_dout  input  BURST_WIDTH  head entry of the first-word-fall-through output FIFO; valid while empty_outfifo=0.
REQ-006 fifo_last  input  1  head entry is the last beat of its packet.
REQ-007 fifo_hdr  input  1  head entry is a header beat.
REQ-008 empty_outfifo  input  1  output FIFO empty.
REQ-009 pop_outfifo  output  1  consume the head entry this cycle.
REQ-010 m_tdata  output  BURST_WIDTH  AXI-stream master data.
REQ-011 m_tvalid  output  1  AXI-stream master valid.
REQ-012 m_tready  input  1  downstream ready.
REQ-013 m_tlast  output  1  AXI-stream master last.
REQ-014 state  output  3  current FSM state code.
REQ-015 beat_cnt  output  16  beats accepted for the current packet.
REQ-016 pkt_cnt  output  32  packets fully transmitted.
REQ-017 err_hdr  output  1  sticky header-protocol error.

Function
REQ-018 FSM state codes: IDLE=0, HDR=1, DATA=2, DROP=3; no other codes reachable.
REQ-019 Output stage: one register holding m_tdata/m_tlast, with m_tvalid as its occupancy bit.
REQ-020 Load condition (IDLE/HDR/DATA): empty_outfifo=0 and (m_tvalid=0 or m_tready=1); pop_outfifo equals the load condition.
REQ-021 Latency: a popped entry appears on m_tdata with m_tvalid=1 on the following cycle.
REQ-022 Full throughput: with m_tready held at 1 and the FIFO non-empty, one beat per cycle.
REQ-023 m_tvalid holds at 1 with m_tdata/m_tlast stable until m_tready=1 (AXI-stream rule).
REQ-024 IDLE, popped entry with fifo_hdr=1 and fifo_last=0: load it; beat_cnt=1; go to HDR.
REQ-025 IDLE, popped entry with fifo_hdr=1 and fifo_last=1: load it; stay in IDLE.
REQ-026 IDLE, head entry with fifo_hdr=0: set err_hdr, do not load it, go to DROP.
REQ-027 HDR: each loaded entry increments beat_cnt.
REQ-028 HDR: once HDR_BEATS header beats have been loaded, go to DATA.
REQ-029 HDR, loaded entry with fifo_hdr=0 before HDR_BEATS is reached (short header): set err_hdr; go to DATA.
REQ-030 HDR: fifo_last=1 on any loaded entry returns the FSM to IDLE.
REQ-031 DATA: fifo_hdr is ignored; fifo_last=1 on a loaded entry returns the FSM to IDLE.
REQ-032 DROP: pop_outfifo = !empty_outfifo; the output register is not loaded.
REQ-033 DROP: a popped entry with fifo_last=1 returns the FSM to IDLE.
REQ-034 beat_cnt saturates at 16'hFFFF.
REQ-035 pkt_cnt increments on m_tvalid & m_tready & m_tlast and wraps modulo 2^32.
REQ-036 When m_tready=1 and a new load occur in the same cycle, the register takes the new entry with no bubble.
REQ-037 err_hdr clears only on reset.

Reset
REQ-038 On reset_n=0, immediately and asynchronously: state=IDLE, m_tvalid=0, m_tlast=0, m_tdata=0, pop_outfifo=0, beat_cnt=0, pkt_cnt=0, err_hdr=0.
REQ-039 Reset mid-packet discards the registered beat; after release, the first fifo_hdr=0 entry takes the DROP path.

Structure
REQ-040 Shared package holds BURST_WIDTH, HDR_BEATS and the state codes, common with the compressor controller.
REQ-041 One sub-module, axis_out_reg, implements the output register and load/valid logic; the FSM and counters stay in the top level.

Verification
REQ-042 Packet of 4 header beats plus 3 data beats (last on beat 7), m_tready=1 -> 7 consecutive m_tvalid beats, m_tlast on the 7th only, pkt_cnt=1, beat_cnt=7, err_hdr=0.
REQ-043 Same packet with m_tready toggling 1/0 each cycle -> data never changes while m_tvalid=1 and m_tready=0; beat order preserved; pkt_cnt=1.
REQ-044 Packet whose first entry has fifo_hdr=0, 5 beats -> no m_tvalid, 5 pops, err_hdr=1, state back to IDLE; next good packet transmits normally.
REQ-045 Header of only 2 beats followed by data -> err_hdr=1, all beats transmitted, FSM passes through DATA.
REQ-046 reset_n asserted with m_tvalid=1 in DATA -> m_tvalid=0 and state=0 with no clock edge; counters=0.
REQ-047 pkt_cnt preset near 32'hFFFFFFFF by forcing, one packet sent -> pkt_cnt wraps to 0.
